inst_fetch: RTL
===============

Name: inst_fetch

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of instruction decode and supplies it with `inst`, `if_pc` and `if_branch_taken`. It holds the PC, drives the instruction-memory address, and predecodes conditional branches against a BHT of 2-bit counters. It redirects on ID jumps and EX mispredicts, and honours hazard stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_BITS, 6, log2 of BHT entry count; index = pc[BHT_BITS+1:2].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  fetch address; equals current PC (combinational from PC register).
- imem_data  in  32  instruction at imem_addr; combinational memory, valid same cycle.
- stall  in  1  hazard hold from decode/forward logic.
- id_force_jump  in  1  decode has J/JAL/JR in IF/ID.
- id_next_pc  in  32  jump target from decode.
- ex_mispredict  in  1  EX resolved a branch opposite to its prediction.
- ex_correct_pc  in  32  correct continuation PC from EX.
- ex_branch_valid  in  1  EX resolved a conditional branch this cycle; triggers BHT update.
- ex_branch_pc  in  32  PC of the resolved branch.
- ex_branch_taken  in  1  actual outcome of the resolved branch.
- inst  out  32  IF/ID instruction.
- if_pc  out  32  IF/ID PC of inst.
- if_branch_taken  out  1  IF/ID prediction bit travelling with inst.

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_PC; inst=0 (NOP), if_pc=0, if_branch_taken=0.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - The first fetch occurs in the first clk edge after rst deasserts.
- Predecode (combinational on imem_data):
  - is_cond_branch = opcode in {1,4,5,6,7}.
  - pred_target = PC + 4 + (sign-extended imm << 2), 32-bit wrap-around.
  - pred_taken = is_cond_branch && BHT[PC idx][1].
- Next-state priority, per clk edge:
  1. ex_mispredict: PC <= ex_correct_pc; IF/ID <= bubble (inst=0, if_pc=0, if_branch_taken=0). Overrides stall and id_force_jump.
  2. stall: PC and IF/ID hold. id_force_jump is ignored; decode re-asserts it once the stall clears.
  3. id_force_jump: PC <= id_next_pc; IF/ID <= bubble (the sequentially fetched instruction is discarded).
  4. Otherwise: IF/ID <= {imem_data, PC, pred_taken}; PC <= pred_taken ? pred_target : PC+4.
- Bubble encoding is all-zero (sll $0,$0,0), which decode treats as a harmless NOP.
- PC+4 wraps modulo 2^32. PC bits [1:0] are never forced; targets are trusted word-aligned.
- BHT update:
  - On ex_branch_valid, entry at ex_branch_pc[BHT_BITS+1:2] increments (saturating at 3) if ex_branch_taken, else decrements (saturating at 0).
  - The update happens regardless of stall or mispredict.
  - Same-cycle lookup of the same index reads the pre-update value (read-before-write).
- Latency: an instruction presented at imem_data appears on inst one cycle later. Redirect penalty is 1 bubble for a jump and 2 bubbles for a mispredict (the ID/EX flush is decode's responsibility).

Optional Feature:
- Macro `BRANCH_PREDICT_EN`.
- Defined: BHT and predecode as above.
- Undefined:
  - No BHT storage is synthesized.
  - pred_taken is constant 0 and if_branch_taken is always 0 (static not-taken).
  - ex_branch_valid and ex_branch_pc are ignored.
  - Mispredict redirect still functions.

Test Plan:
1. Reset → sequential fetch: rst pulse with RESET_PC=0 and NOP memory → inst=0 during reset; if_pc sequence 0,4,8,12 on successive edges; imem_addr leads if_pc by one cycle.
2. Stall vs force-jump: stall=1 for 3 cycles at PC=0x10 with id_force_jump=1, id_next_pc=0x200 → PC and IF/ID frozen. Release stall → PC=0x200 next edge and IF/ID bubble (inst=0).
3. Mispredict overrides stall: stall=1, id_force_jump=1, ex_mispredict=1, ex_correct_pc=0x80 in the same cycle → PC=0x80 and IF/ID bubble.
4. BHT training: beq at 0x40 with imm=4. Three EX updates taken → counter 3; next fetch of 0x40 gives if_branch_taken=1 and PC=0x54. Two not-taken updates → counter 1; fetch gives PC=0x44 and if_branch_taken=0.
5. BHT saturation and same-cycle read: five not-taken updates → counter stays 0. Update taken on the same cycle 0x40 is fetched → prediction uses the old value 0 (not taken).
6. BRANCH_PREDICT_EN undefined: repeat test 4 → if_branch_taken always 0 and PC always +4 past the branch.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage with IF/ID register and optional 2-bit BHT branch prediction.
// Ports: clk/rst (async active-high); imem_addr/imem_data to a combinational instruction memory;
// stall, id_force_jump/id_next_pc, ex_mispredict/ex_correct_pc redirect and hold controls;
// ex_branch_valid/ex_branch_pc/ex_branch_taken train the BHT; inst/if_pc/if_branch_taken feed decode.
// Macro BRANCH_PREDICT_EN enables the BHT; without it fetch is static not-taken.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        id_force_jump,
  input  logic [31:0] id_next_pc,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_correct_pc,
  input  logic        ex_branch_valid,
  input  logic [31:0] ex_branch_pc,
  input  logic        ex_branch_taken,
  output logic [31:0] inst,
  output logic [31:0] if_pc,
  output logic        if_branch_taken
);
  logic [31:0] pc;
  logic [31:0] pred_target;
  logic        pred_taken;
  logic        unused;
  assign imem_addr   = pc;
  assign pred_target = pc + 32'd4 + {{14{imem_data[15]}}, imem_data[15:0], 2'b00};
  assign unused      = ^{imem_data[25:16], ex_branch_pc, ex_branch_valid, ex_branch_taken};
`ifdef BRANCH_PREDICT_EN
  localparam int N = 1 << BHT_BITS;
  logic [1:0]          bht [N];
  logic [BHT_BITS-1:0] fetch_idx;
  logic [BHT_BITS-1:0] upd_idx;
  logic [5:0]          opcode;
  logic                is_cond_branch;
  assign fetch_idx      = pc[BHT_BITS+1:2];
  assign upd_idx        = ex_branch_pc[BHT_BITS+1:2];
  assign opcode         = imem_data[31:26];
  assign is_cond_branch = opcode == 6'd1 || (opcode >= 6'd4 && opcode <= 6'd7);
  // Nonblocking update gives read-before-write for a same-cycle lookup.
  assign pred_taken     = is_cond_branch && bht[fetch_idx][1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) bht[i] <= 2'b01;
    end else if (ex_branch_valid) begin
      bht[upd_idx] <= ex_branch_taken ? (bht[upd_idx] == 2'b11 ? 2'b11 : bht[upd_idx] + 2'b01)
                                      : (bht[upd_idx] == 2'b00 ? 2'b00 : bht[upd_idx] - 2'b01);
    end
  end
`else
  assign pred_taken = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc              <= RESET_PC;
      inst            <= '0;
      if_pc           <= '0;
      if_branch_taken <= 1'b0;
    end else if (ex_mispredict) begin
      pc              <= ex_correct_pc;
      inst            <= '0;
      if_pc           <= '0;
      if_branch_taken <= 1'b0;
    end else if (!stall) begin
      if (id_force_jump) begin
        pc              <= id_next_pc;
        inst            <= '0;
        if_pc           <= '0;
        if_branch_taken <= 1'b0;
      end else begin
        pc              <= pred_taken ? pred_target : pc + 32'd4;
        inst            <= imem_data;
        if_pc           <= pc;
        if_branch_taken <= pred_taken;
      end
    end
  end
endmodule
